rob_commit_ctrl: RTL and testbench

Head-side consumer of the ROB core: inspects the ROB read port every cycle and retires completed entries in order to the architectural-state commit interface. It silently discards cancelled entries and converts an excepting head entry into a trap report plus a one-cycle ROB flush. It also keeps a retired-instruction counter and a head-stall watchdog.

---
 rtl/rob_commit_pkg.sv | 50 +++++
 rtl/commit_stall_wdt.sv | 41 ++++
 rtl/rob_commit_ctrl.sv | 162 ++++++++++++++++
 tb/tb_rob_commit_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_commit_pkg.sv
// ----------------------------------------------------------------------------
// rob_commit_pkg
// Shared types for the ROB commit controller.
//   state_e     : commit FSM states (RUN, TRAP, FLUSH, DRAIN)
//   head_cls_e  : classification of the ROB head entry as seen this cycle
//   EXC_BIT     : position of the exception flag inside the ROB data word
//   CAUSE_LSB   : lowest bit of the exception cause inside the ROB data word
//   classify()  : maps the raw head signals onto a head_cls_e value
// ----------------------------------------------------------------------------
package rob_commit_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        TRAP  = 2'd1,
        FLUSH = 2'd2,
        DRAIN = 2'd3
    } state_e;

    typedef enum logic [2:0] {
        H_NONE = 3'd0,
        H_WAIT = 3'd1,
        H_CAN  = 3'd2,
        H_EXC  = 3'd3,
        H_OK   = 3'd4
    } head_cls_e;

    localparam int EXC_BIT   = 0;
    localparam int CAUSE_LSB = 1;

    // Cancel dominates: a cancelled entry is discarded whether or not it
    // completed and whatever its exception flag says.
    function automatic head_cls_e classify(input logic empty,
                                           input logic cancel,
                                           input logic complete,
                                           input logic exc);
        head_cls_e cls;
        if (empty)
            cls = H_NONE;
        else if (cancel)
            cls = H_CAN;
        else if (!complete)
            cls = H_WAIT;
        else if (exc)
            cls = H_EXC;
        else
            cls = H_OK;
        return cls;
    endfunction

endpackage

// File: rtl/commit_stall_wdt.sv
// ----------------------------------------------------------------------------
// commit_stall_wdt
// Head-stall watchdog: a counter that saturates at TIMEOUT and a one-cycle
// pulse produced in the cycle in which the count steps TIMEOUT-1 -> TIMEOUT.
// Ports:
//   clk_i    : clock
//   arst_ni  : asynchronous active-low reset
//   inc      : head is stalled this cycle, advance the count
//   clr      : head popped / ROB empty / not running, clear the count
//   fire     : one-cycle timeout pulse
// ----------------------------------------------------------------------------
module commit_stall_wdt #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk_i,
    input  logic arst_ni,
    input  logic inc,
    input  logic clr,
    output logic fire
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != LIMIT)) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Fires in the cycle whose clock edge completes the step to LIMIT, so
    // once saturated no further pulses are produced.
    assign fire = inc && !clr && (cnt == (LIMIT - 1'b1));

endmodule

// File: rtl/rob_commit_ctrl.sv
// ----------------------------------------------------------------------------
// rob_commit_ctrl
// In-order retirement stage on the head side of the ROB. Completed heads are
// offered to the commit interface, cancelled heads are popped silently, and
// an excepting head turns into a trap report, a one-cycle ROB flush and a
// drain of whatever is left in the ROB.
// Ports:
//   clk_i, arst_ni         : clock, asynchronous active-low reset
//   rob_empty_i            : ROB holds no entries
//   rob_rentrynum_i        : head entry number
//   rob_rtag_i             : head tag
//   rob_rcomplete_i        : head finished executing
//   rob_rcancel_i          : head was cancelled
//   rob_rdata_i            : head data, bit 0 exception flag, rest cause
//   rob_rden_o             : pop the ROB head
//   rob_flush_o            : flush the ROB
//   commit_valid_o/ready_i : retire handshake
//   commit_tag_o/entry_o   : identity of the retiring instruction
//   trap_valid_o           : one-cycle trap report
//   trap_tag_o/cause_o     : tag and cause of the excepting instruction
//   retired_cnt_o          : number of retired instructions (wraps)
//   stall_timeout_o        : one-cycle head-stall watchdog pulse
//
// Handshake: commit_valid_o may only rise in RUN with a completed,
// non-excepting, non-cancelled head. Once up it stays up with the same tag
// and entry until commit_ready_i is seen high in the same cycle; that cycle
// is the transfer, the head is popped and the retired count advances.
// ----------------------------------------------------------------------------
module rob_commit_ctrl
    import rob_commit_pkg::*;
#(
    parameter int DWIDTH  = 4,
    parameter int IDWIDTH = 8,
    parameter int CNTW    = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic               clk_i,
    input  logic               arst_ni,
    input  logic               rob_empty_i,
    input  logic [IDWIDTH-1:0] rob_rentrynum_i,
    input  logic [IDWIDTH-1:0] rob_rtag_i,
    input  logic               rob_rcomplete_i,
    input  logic               rob_rcancel_i,
    input  logic [DWIDTH-1:0]  rob_rdata_i,
    output logic               rob_rden_o,
    output logic               rob_flush_o,
    output logic               commit_valid_o,
    input  logic               commit_ready_i,
    output logic [IDWIDTH-1:0] commit_tag_o,
    output logic [IDWIDTH-1:0] commit_entry_o,
    output logic               trap_valid_o,
    output logic [IDWIDTH-1:0] trap_tag_o,
    output logic [DWIDTH-2:0]  trap_cause_o,
    output logic [CNTW-1:0]    retired_cnt_o,
    output logic               stall_timeout_o
);

    state_e             state;
    head_cls_e          head_cls;
    logic [IDWIDTH-1:0] trap_tag_q;
    logic [DWIDTH-2:0]  trap_cause_q;
    logic [CNTW-1:0]    retired_q;
    logic               wdt_inc;
    logic               wdt_clr;

    assign head_cls = classify(rob_empty_i, rob_rcancel_i, rob_rcomplete_i,
                               rob_rdata_i[EXC_BIT]);

    // Outputs are decoded from the state and the live head so that a ready
    // head retires in the same cycle it appears.
    always_comb begin
        rob_rden_o     = 1'b0;
        rob_flush_o    = 1'b0;
        commit_valid_o = 1'b0;
        trap_valid_o   = 1'b0;
        case (state)
            RUN: begin
                commit_valid_o = (head_cls == H_OK);
                rob_rden_o     = ((head_cls == H_OK) && commit_ready_i) ||
                                 (head_cls == H_CAN);
            end
            TRAP: begin
                trap_valid_o = 1'b1;
                // The excepting entry is still at the head; gating with empty
                // only guarantees we never pop an empty ROB.
                rob_rden_o   = !rob_empty_i;
            end
            FLUSH: begin
                rob_flush_o = 1'b1;
            end
            DRAIN: begin
                // Everything left is younger than the trap; pop regardless of
                // its cancel or complete bits.
                rob_rden_o = !rob_empty_i;
            end
            default: begin
                rob_rden_o = 1'b0;
            end
        endcase
    end

    // Tag and entry are only shown alongside a valid offer so that the bus is
    // quiet while nothing is retiring.
    assign commit_tag_o   = commit_valid_o ? rob_rtag_i      : '0;
    assign commit_entry_o = commit_valid_o ? rob_rentrynum_i : '0;

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state        <= RUN;
            trap_tag_q   <= '0;
            trap_cause_q <= '0;
            retired_q    <= '0;
        end else begin
            if (commit_valid_o && commit_ready_i) begin
                retired_q <= retired_q + 1'b1;
            end
            case (state)
                RUN: begin
                    if (head_cls == H_EXC) begin
                        trap_tag_q   <= rob_rtag_i;
                        trap_cause_q <= rob_rdata_i[DWIDTH-1:CAUSE_LSB];
                        state        <= TRAP;
                    end
                end
                TRAP: begin
                    state <= FLUSH;
                end
                FLUSH: begin
                    state <= DRAIN;
                end
                DRAIN: begin
                    if (rob_empty_i) begin
                        state <= RUN;
                    end
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

    assign trap_tag_o    = trap_tag_q;
    assign trap_cause_o  = trap_cause_q;
    assign retired_cnt_o = retired_q;

    // Only a stalled head in RUN advances the watchdog; any pop, an empty
    // ROB or leaving RUN restarts it.
    assign wdt_inc = (state == RUN) && (head_cls == H_WAIT);
    assign wdt_clr = rob_rden_o || rob_empty_i || (state != RUN);

    commit_stall_wdt #(
        .TIMEOUT (TIMEOUT)
    ) u_wdt (
        .clk_i   (clk_i),
        .arst_ni (arst_ni),
        .inc     (wdt_inc),
        .clr     (wdt_clr),
        .fire    (stall_timeout_o)
    );

endmodule

// File: tb/tb_rob_commit_ctrl.sv
// ----------------------------------------------------------------------------
// tb_rob_commit_ctrl
// Bench for rob_commit_ctrl. The ROB is modelled as a queue of entries whose
// head drives the DUT; expected retirements and traps are derived from the
// program order of the pushed entries, while per-cycle outputs come from a
// small phase model of the retire/trap/flush/drain sequence.
// ----------------------------------------------------------------------------
module tb_rob_commit_ctrl;

    localparam int DW = 4;
    localparam int IW = 8;
    localparam int CW = 4;
    localparam int TO = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          arst_n;
    logic          rob_empty;
    logic [IW-1:0] rob_entry;
    logic [IW-1:0] rob_tag;
    logic          rob_complete;
    logic          rob_cancel;
    logic [DW-1:0] rob_data;
    logic          rob_rden;
    logic          rob_flush;
    logic          commit_valid;
    logic          commit_ready;
    logic [IW-1:0] commit_tag;
    logic [IW-1:0] commit_entry;
    logic          trap_valid;
    logic [IW-1:0] trap_tag;
    logic [DW-2:0] trap_cause;
    logic [CW-1:0] retired_cnt;
    logic          stall_timeout;

    rob_commit_ctrl #(
        .DWIDTH  (DW),
        .IDWIDTH (IW),
        .CNTW    (CW),
        .TIMEOUT (TO)
    ) dut (
        .clk_i           (clk),
        .arst_ni         (arst_n),
        .rob_empty_i     (rob_empty),
        .rob_rentrynum_i (rob_entry),
        .rob_rtag_i      (rob_tag),
        .rob_rcomplete_i (rob_complete),
        .rob_rcancel_i   (rob_cancel),
        .rob_rdata_i     (rob_data),
        .rob_rden_o      (rob_rden),
        .rob_flush_o     (rob_flush),
        .commit_valid_o  (commit_valid),
        .commit_ready_i  (commit_ready),
        .commit_tag_o    (commit_tag),
        .commit_entry_o  (commit_entry),
        .trap_valid_o    (trap_valid),
        .trap_tag_o      (trap_tag),
        .trap_cause_o    (trap_cause),
        .retired_cnt_o   (retired_cnt),
        .stall_timeout_o (stall_timeout)
    );

    // ---------------- reference model state ----------------
    typedef struct {
        logic [IW-1:0] tag;
        logic [IW-1:0] entry;
        logic          complete;
        logic          cancel;
        logic [DW-1:0] data;
    } ent_t;

    ent_t              rob_q[$];
    logic [IW-1:0]     exp_q[$];        // tags expected to retire, in order
    logic [IW+DW-2:0]  trap_q[$];       // {tag, cause} expected to trap
    int                phase;           // 0 run, 1 trap report, 2 flush, 3 drain
    int                m_retired;
    int                m_stall;
    bit                exc_pending;     // an exception older than new pushes
    int                next_entry;
    int                pulses;
    int                total;
    int                bad;

    // ---------------- scoreboard check ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic push(input logic [IW-1:0] tag, input bit complete, input bit cancel,
                        input logic [DW-1:0] data);
        ent_t e;
        e.tag      = tag;
        e.entry    = IW'(next_entry % 16);
        e.complete = complete;
        e.cancel   = cancel;
        e.data     = data;
        next_entry++;
        rob_q.push_back(e);
        // Program-order outcome: only the first live exception traps, and
        // everything behind it is flushed instead of retired.
        if (!cancel && !exc_pending) begin
            if (data[0]) begin
                exc_pending = 1'b1;
                trap_q.push_back({tag, data[DW-1:1]});
            end else begin
                exp_q.push_back(tag);
            end
        end
    endtask

    task automatic drive_head();
        if (rob_q.size() == 0) begin
            rob_empty    = 1'b1;
            rob_tag      = '0;
            rob_entry    = '0;
            rob_complete = 1'b0;
            rob_cancel   = 1'b0;
            rob_data     = '0;
        end else begin
            rob_empty    = 1'b0;
            rob_tag      = rob_q[0].tag;
            rob_entry    = rob_q[0].entry;
            rob_complete = rob_q[0].complete;
            rob_cancel   = rob_q[0].cancel;
            rob_data     = rob_q[0].data;
        end
    endtask

    task automatic model_reset();
        rob_q.delete();
        exp_q.delete();
        trap_q.delete();
        phase       = 0;
        m_retired   = 0;
        m_stall     = 0;
        exc_pending = 1'b0;
    endtask

    // One clock cycle: drive head, check at negedge, advance model at posedge.
    task automatic step();
        bit emp, ok, can, exc, wait_h;
        bit e_cv, e_rden, e_fl, e_tv, e_st;
        logic [IW+DW-2:0] tv;
        drive_head();
        emp = (rob_q.size() == 0);
        ok = 0; can = 0; exc = 0; wait_h = 0;
        if (!emp) begin
            can    = rob_q[0].cancel;
            exc    = !can && rob_q[0].complete && rob_q[0].data[0];
            ok     = !can && rob_q[0].complete && !rob_q[0].data[0];
            wait_h = !can && !rob_q[0].complete;
        end
        e_cv   = (phase == 0) && ok;
        e_rden = (phase == 0) ? ((ok && commit_ready) || can) :
                 ((phase == 1) || (phase == 3)) ? !emp : 1'b0;
        e_fl   = (phase == 2);
        e_tv   = (phase == 1);
        e_st   = (phase == 0) && wait_h && (m_stall == TO - 1);

        @(negedge clk);
        check("commit_valid", 32'(commit_valid), 32'(e_cv));
        check("rob_rden", 32'(rob_rden), 32'(e_rden));
        check("rob_flush", 32'(rob_flush), 32'(e_fl));
        check("trap_valid", 32'(trap_valid), 32'(e_tv));
        check("stall_timeout", 32'(stall_timeout), 32'(e_st));
        check("retired_cnt", 32'(retired_cnt), 32'(m_retired));
        if (e_cv) begin
            check("commit_tag", 32'(commit_tag), 32'(rob_q[0].tag));
            check("commit_entry", 32'(commit_entry), 32'(rob_q[0].entry));
        end
        if (commit_valid && commit_ready) begin
            if (exp_q.size() == 0) check("commit_extra", 32'(commit_tag), 32'hFFFF_FFFF);
            else                   check("commit_order", 32'(commit_tag), 32'(exp_q.pop_front()));
        end
        if (trap_valid) begin
            if (trap_q.size() == 0) begin
                check("trap_extra", 32'(trap_tag), 32'hFFFF_FFFF);
            end else begin
                tv = trap_q.pop_front();
                check("trap_tag", 32'(trap_tag), 32'(tv[IW+DW-2:DW-1]));
                check("trap_cause", 32'(trap_cause), 32'(tv[DW-2:0]));
            end
        end
        if (stall_timeout) pulses++;

        @(posedge clk);
        if (e_rden) rob_q.delete(0);
        if ((phase == 0) && ok && commit_ready) m_retired = (m_retired + 1) % (1 << CW);
        m_stall = ((phase == 0) && wait_h) ? ((m_stall < TO) ? m_stall + 1 : TO) : 0;
        case (phase)
            0: if (exc) phase = 1;
            1: phase = 2;
            2: phase = 3;
            default: if (emp) begin phase = 0; exc_pending = 1'b0; end
        endcase
        #1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int idx;
        int guard;
        total = 0; bad = 0; pulses = 0; next_entry = 0;
        model_reset();
        commit_ready = 1'b0;
        arst_n       = 1'b0;
        drive_head();

        // reset with empty ROB: everything quiet
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_rden", 32'(rob_rden), 32'd0);
        check("rst_flush", 32'(rob_flush), 32'd0);
        check("rst_cvalid", 32'(commit_valid), 32'd0);
        check("rst_ctag", 32'(commit_tag), 32'd0);
        check("rst_tvalid", 32'(trap_valid), 32'd0);
        check("rst_ttag", 32'(trap_tag), 32'd0);
        check("rst_tcause", 32'(trap_cause), 32'd0);
        check("rst_retired", 32'(retired_cnt), 32'd0);
        check("rst_stall", 32'(stall_timeout), 32'd0);
        arst_n = 1'b1;
        @(posedge clk); #1;

        // in-order commit of three ready heads
        commit_ready = 1'b1;
        push(8'd5, 1, 0, 4'b0000);
        push(8'd6, 1, 0, 4'b0000);
        push(8'd7, 1, 0, 4'b0000);
        repeat (3) step();
        check("inorder_retired", 32'(retired_cnt), 32'd3);
        check("inorder_empty", 32'(rob_q.size()), 32'd0);

        // backpressure: four cycles of ready low, retire on the fifth
        push(8'd9, 1, 0, 4'b0000);
        commit_ready = 1'b0;
        repeat (4) step();
        check("bp_held", 32'(rob_q.size()), 32'd1);
        commit_ready = 1'b1;
        step();
        check("bp_popped", 32'(rob_q.size()), 32'd0);
        check("bp_retired", 32'(retired_cnt), 32'd4);

        // cancelled, incomplete head is discarded
        push(8'h20, 0, 1, 4'b0000);
        step();
        check("can_popped", 32'(rob_q.size()), 32'd0);
        check("can_retired", 32'(retired_cnt), 32'd4);

        // exception with two younger entries
        push(8'h12, 1, 0, 4'b0111);
        push(8'h13, 1, 0, 4'b0000);
        push(8'h14, 1, 0, 4'b0000);
        repeat (6) step();
        check("exc_trap_tag", 32'(trap_tag), 32'h12);
        check("exc_trap_cause", 32'(trap_cause), 32'd3);
        check("exc_retired", 32'(retired_cnt), 32'd4);
        check("exc_drained", 32'(rob_q.size()), 32'd0);

        // watchdog: stalled head for 20 cycles, one pulse
        pulses = 0;
        push(8'h30, 0, 0, 4'b0000);
        repeat (20) step();
        check("wdt_one_pulse", 32'(pulses), 32'd1);
        rob_q[0].complete = 1'b1;
        step();
        push(8'h31, 0, 0, 4'b0000);
        repeat (8) step();
        check("wdt_rearmed", 32'(pulses), 32'd2);
        rob_q[0].complete = 1'b1;
        step();
        check("wdt_retired", 32'(retired_cnt), 32'd6);

        // counter wrap at 2^CW
        for (int i = 0; i < 12; i++) push(8'(8'h50 + i), 1, 0, 4'b0000);
        repeat (12) step();
        check("wrap_retired", 32'(retired_cnt), 32'd2);

        // asynchronous reset while in the flush cycle
        push(8'h40, 1, 0, 4'b0101);
        push(8'h41, 1, 0, 4'b0000);
        repeat (2) step();
        drive_head();
        #2;
        arst_n = 1'b0;
        #1;
        check("midrst_flush", 32'(rob_flush), 32'd0);
        check("midrst_tvalid", 32'(trap_valid), 32'd0);
        check("midrst_ttag", 32'(trap_tag), 32'd0);
        check("midrst_retired", 32'(retired_cnt), 32'd0);
        model_reset();
        drive_head();
        @(negedge clk);
        arst_n = 1'b1;
        @(posedge clk); #1;
        step();

        // randomized traffic
        for (int c = 0; c < 1500; c++) begin
            if ((phase == 0) && (rob_q.size() < 8) && ($urandom_range(0, 1) == 1)) begin
                int kind;
                kind = $urandom_range(0, 9);
                push(8'($urandom_range(0, 255)), bit'($urandom_range(0, 1)), kind < 2,
                     (kind == 2) ? {3'($urandom_range(0, 7)), 1'b1} : 4'b0000);
            end
            if ((rob_q.size() > 0) && ($urandom_range(0, 2) == 0)) begin
                idx = $urandom_range(0, rob_q.size() - 1);
                rob_q[idx].complete = 1'b1;
            end
            commit_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        // drain what is left
        commit_ready = 1'b1;
        guard = 0;
        while (((rob_q.size() != 0) || (phase != 0)) && (guard < 200)) begin
            foreach (rob_q[k]) rob_q[k].complete = 1'b1;
            step();
            guard++;
        end
        check("final_drain_bound", 32'(guard < 200), 32'd1);
        check("final_exp_left", 32'(exp_q.size()), 32'd0);
        check("final_trap_left", 32'(trap_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
